mul_div_sequencer: RTL and testbench
====================================

MUL_DIV_SEQUENCER -- requirements
Module: mul_div_sequencer

Interface
REQ-001 The block SHALL use one clock and one reset: the reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  E-stage instruction issues a HI/LO operation this cycle.
REQ-005 mulCtrl  input  4  operation code from the shared constants (mt* codes).
REQ-006 cancel  input  1  E-stage instruction killed by an exception or flush; suppresses the start in the same cycle.
REQ-007 operandA / operandB  input  32 each  rs / rt values.
REQ-008 mulOutputSel  input  1  1 = HI, 0 = LO.
REQ-009 hiloUse  input  1  D-stage instruction reads or writes HI/LO (mf*, mt*, mul-class).
REQ-010 busy  output  1  a multi-cycle operation is in flight.
REQ-011 stall  output  1  request to freeze D and earlier stages.
REQ-012 result  output  32  selected HI or LO value.
REQ-013 hi / lo  output  32 each  architectural HI/LO registers, for debug.

Function
REQ-014 The block SHALL implement two states: IDLE and BUSY.
REQ-015 The block SHALL accept an operation only when state is IDLE, start=1, cancel=0 and mulCtrl!=mtDisabled.
REQ-016 mthi/mtlo SHALL write operandA into HI or LO at the accepting edge, with no BUSY entry and the new value visible the next cycle.
REQ-017 mult, multu, madd, maddu and msub SHALL have latency 5; div and divu SHALL have latency 10.
REQ-018 On accept of a multi-cycle operation: operands and the operation code SHALL be latched, the counter SHALL be loaded with latency-1, and the state SHALL become BUSY.
REQ-019 busy SHALL be high for exactly latency cycles, starting the cycle after the accept edge.
REQ-020 In BUSY the counter SHALL decrement each cycle; at counter==0 the next edge SHALL commit HI/LO and return the state to IDLE.
REQ-021 The new HI/LO values SHALL be visible in the first cycle busy is low.
REQ-022 Result width and arithmetic rules:
- mult/multu: {HI,LO} = 64-bit signed/unsigned product.
- madd/maddu: {HI,LO} += product.
- msub: {HI,LO} -= signed product.
- All wrap modulo 2^64.
REQ-023 div/divu SHALL produce LO = quotient and HI = remainder; the remainder sign SHALL follow the dividend, truncating toward zero.
REQ-024 A divisor of 0 SHALL leave HI and LO unchanged while still consuming 10 busy cycles.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO = 0x80000000, HI = 0.
REQ-026 stall SHALL equal hiloUse & (busy | (start & ~cancel & multi-cycle op)).
REQ-027 start in BUSY SHALL be ignored, and a bench assertion SHALL flag it because the pipeline must have stalled.
REQ-028 cancel SHALL have no effect once BUSY; an accepted operation always completes.
REQ-029 result SHALL be combinational: mulOutputSel ? HI : LO, taken from the committed registers.

Reset
REQ-030 Asserting reset SHALL, asynchronously:
- set state to IDLE;
- set counter, HI, LO and latched operands to 0;
- set busy=0 and stall=0.
REQ-031 Reset mid-operation SHALL abort the operation with no HI/LO commit.
REQ-032 After reset is released, the first edge SHALL be able to accept an operation.

Structure
REQ-033 The mt* codes SHALL live in the shared constants package, using these values: mtDisabled=0, mtMultiply=1, mtMultiplyUnsigned=2, mtDivide=3, mtDivideUnsigned=4, mtSetHI=5, mtSetLO=6, mtMADD=7, mtMADDU=8, mtMSUB=9.
REQ-034 The latency constants MUL_LATENCY=5 and DIV_LATENCY=10 SHALL also live in the shared constants package.
REQ-035 The state enum SHALL be local to the block.
REQ-036 Arithmetic SHALL sit in one combinational sub-module, hilo_alu, which takes the operation, operands and current HI/LO and returns the next {HI,LO}.

Verification
REQ-037 The bench SHALL cover these directed scenarios:
- mult 0xFFFFFFFF x 2: busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands: HI=1, LO=0xFFFFFFFE.
- div -7 / 2: busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7 / 0: HI/LO unchanged after 10 cycles.
- mthi 0x12345678 then mfhi the next cycle: result=0x12345678, with no stall and no busy.
- madd with HI=0, LO=0xFFFFFFFF and operands 1 x 1: HI=1, LO=0. msub with 1 x 1 from zero: HI=LO=0xFFFFFFFF.
- hiloUse=1 during a div: stall high in the accept cycle and for all 10 busy cycles, low afterwards. start with cancel=1: no busy, HI/LO unchanged.
- reset asserted at busy cycle 3 of a mult: busy=0 immediately, HI=LO=0, with no later commit.

Source files
------------

// File: rtl/mul_div_sequencer_pkg.sv
// rtl/mul_div_sequencer_pkg.sv - shared HI/LO operation codes, latencies and helpers
package mul_div_sequencer_pkg;

   localparam logic [3:0] mtDisabled         = 4'd0;
   localparam logic [3:0] mtMultiply         = 4'd1;
   localparam logic [3:0] mtMultiplyUnsigned = 4'd2;
   localparam logic [3:0] mtDivide           = 4'd3;
   localparam logic [3:0] mtDivideUnsigned   = 4'd4;
   localparam logic [3:0] mtSetHI            = 4'd5;
   localparam logic [3:0] mtSetLO            = 4'd6;
   localparam logic [3:0] mtMADD             = 4'd7;
   localparam logic [3:0] mtMADDU            = 4'd8;
   localparam logic [3:0] mtMSUB             = 4'd9;

   localparam int MUL_LATENCY = 5;
   localparam int DIV_LATENCY = 10;
   localparam int CNT_W       = 4;

   function automatic logic is_multi_cycle(input logic [3:0] op);
      case (op)
         mtMultiply, mtMultiplyUnsigned, mtDivide, mtDivideUnsigned,
         mtMADD, mtMADDU, mtMSUB: return 1'b1;
         default:                 return 1'b0;
      endcase
   endfunction

   // Counter preload: busy lasts exactly latency cycles, counting down to zero.
   function automatic logic [CNT_W-1:0] latency_m1(input logic [3:0] op);
      if (op == mtDivide || op == mtDivideUnsigned)
         return CNT_W'(DIV_LATENCY - 1);
      return CNT_W'(MUL_LATENCY - 1);
   endfunction

endpackage

// File: rtl/mul_div_sequencer_if.sv
// rtl/mul_div_sequencer_if.sv - pipeline-to-HI/LO-unit signal bundle
interface mul_div_sequencer_if;
   logic        start;
   logic [3:0]  mulCtrl;
   logic        cancel;
   logic [31:0] operandA;
   logic [31:0] operandB;
   logic        mulOutputSel;
   logic        hiloUse;
   logic        busy;
   logic        stall;
   logic [31:0] result;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, mulCtrl, cancel, operandA, operandB, mulOutputSel, hiloUse,
      input  busy, stall, result, hi, lo
   );

   modport slave (
      input  start, mulCtrl, cancel, operandA, operandB, mulOutputSel, hiloUse,
      output busy, stall, result, hi, lo
   );
endinterface

// File: rtl/mul_div_sequencer_hilo_alu.sv
// rtl/mul_div_sequencer_hilo_alu.sv - combinational next-{HI,LO} for every HI/LO operation
module hilo_alu
   import mul_div_sequencer_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [31:0] next_hi,
   output logic [31:0] next_lo
);

   logic [63:0] acc, prod_s, prod_u, sum;
   logic [31:0] mag_a, mag_b, b_nz, q_m, r_m, quo_s, rem_s, quo_u, rem_u;

   always_comb begin
      acc    = {hi, lo};
      prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      prod_u = {32'd0, a} * {32'd0, b};
      // Dividing magnitudes keeps 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
      b_nz   = (b == 32'd0) ? 32'd1 : b;
      mag_a  = a[31] ? (~a + 32'd1) : a;
      mag_b  = b[31] ? (~b + 32'd1) : b_nz;
      q_m    = mag_a / mag_b;
      r_m    = mag_a % mag_b;
      quo_s  = (a[31] ^ b[31]) ? (~q_m + 32'd1) : q_m;
      rem_s  = a[31] ? (~r_m + 32'd1) : r_m;
      quo_u  = a / b_nz;
      rem_u  = a % b_nz;
      sum    = acc;
      case (op)
         mtMultiply:         sum = prod_s;
         mtMultiplyUnsigned: sum = prod_u;
         mtDivide:           if (b != 32'd0) sum = {rem_s, quo_s};
         mtDivideUnsigned:   if (b != 32'd0) sum = {rem_u, quo_u};
         mtSetHI:            sum = {a, lo};
         mtSetLO:            sum = {hi, a};
         mtMADD:             sum = acc + prod_s;
         mtMADDU:            sum = acc + prod_u;
         mtMSUB:             sum = acc - prod_s;
         default:            sum = acc;
      endcase
      next_hi = sum[63:32];
      next_lo = sum[31:0];
   end

endmodule

// File: rtl/mul_div_sequencer.sv
// rtl/mul_div_sequencer.sv - HI/LO multiply/divide sequencer with pipeline stall generation
module mul_div_sequencer
   import mul_div_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   mul_div_sequencer_if.slave bus
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [3:0]       op_q;
   logic [31:0]      a_q, b_q, hi_q, lo_q;
   logic [31:0]      alu_hi, alu_lo;
   logic             accept, multi, commit;

   assign multi  = is_multi_cycle(bus.mulCtrl);
   assign accept = (state == IDLE) && bus.start && !bus.cancel && (bus.mulCtrl != mtDisabled);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      commit    = 1'b0;
      case (state)
         IDLE: if (accept && multi) begin
            state_nxt = BUSY;
            cnt_nxt   = latency_m1(bus.mulCtrl);
         end
         BUSY: if (cnt == '0) begin
            state_nxt = IDLE;
            commit    = 1'b1;
         end else begin
            cnt_nxt = cnt - 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // In IDLE the ALU sees the live operation so mthi/mtlo commit at the accepting edge.
   hilo_alu u_alu (
      .op      ((state == BUSY) ? op_q : bus.mulCtrl),
      .a       ((state == BUSY) ? a_q  : bus.operandA),
      .b       ((state == BUSY) ? b_q  : bus.operandB),
      .hi      (hi_q),
      .lo      (lo_q),
      .next_hi (alu_hi),
      .next_lo (alu_lo)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q <= mtDisabled;
         a_q  <= '0;
         b_q  <= '0;
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         if (accept && multi) begin
            op_q <= bus.mulCtrl;
            a_q  <= bus.operandA;
            b_q  <= bus.operandB;
         end
         if (commit || (accept && !multi)) begin
            hi_q <= alu_hi;
            lo_q <= alu_lo;
         end
      end
   end

   assign bus.busy   = (state == BUSY);
   assign bus.stall  = reset && bus.hiloUse &&
                       ((state == BUSY) || (bus.start && !bus.cancel && multi));
   assign bus.result = bus.mulOutputSel ? hi_q : lo_q;
   assign bus.hi     = hi_q;
   assign bus.lo     = lo_q;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// tb/tb_mul_div_sequencer.sv - self-checking bench for mul_div_sequencer
module tb_mul_div_sequencer;
   import mul_div_sequencer_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   passed = 0;
   int   total = 0;
   logic [31:0] m_hi = '0, m_lo = '0;

   mul_div_sequencer_if bus ();

   mul_div_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   // Pipeline must hold start low while the unit is busy.
   always @(negedge clk) begin
      #2;
      if (reset && bus.busy && bus.start) begin
         total++;
         $display("FAIL start_in_busy start=%0b busy=%0b required start=0", bus.start, bus.busy);
      end
   end

   function automatic int exp_lat(input logic [3:0] op);
      case (op)
         mtMultiply, mtMultiplyUnsigned, mtMADD, mtMADDU, mtMSUB: return 5;
         mtDivide, mtDivideUnsigned:                              return 10;
         default:                                                 return 0;
      endcase
   endfunction

   function automatic void model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, q, r;
      longint unsigned ua, ub;
      logic [63:0]     acc;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'({32'd0, a});
      ub  = longint'({32'd0, b});
      acc = {m_hi, m_lo};
      case (op)
         mtMultiply:         acc = sa * sb;
         mtMultiplyUnsigned: acc = ua * ub;
         mtMADD:             acc = acc + sa * sb;
         mtMADDU:            acc = acc + ua * ub;
         mtMSUB:             acc = acc - sa * sb;
         mtSetHI:            acc[63:32] = a;
         mtSetLO:            acc[31:0] = a;
         mtDivide: if (b != 0) begin
            q = sa / sb;
            r = sa % sb;
            acc = {r[31:0], q[31:0]};
         end
         mtDivideUnsigned: if (b != 0) begin
            q = longint'(ua / ub);
            r = longint'(ua % ub);
            acc = {r[31:0], q[31:0]};
         end
         default: ;
      endcase
      m_hi = acc[63:32];
      m_lo = acc[31:0];
   endfunction

   // Issue one operation (caller is just after a negedge) and follow it until busy drops.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_hl, output int n, output logic st0, output int sc);
      bus.start = 1'b1; bus.cancel = 1'b0; bus.mulCtrl = op;
      bus.operandA = a; bus.operandB = b; bus.hiloUse = use_hl;
      #1 st0 = bus.stall;
      @(negedge clk);
      #1;
      bus.start = 1'b0; bus.mulCtrl = mtDisabled;
      model_apply(op, a, b);
      n = 0; sc = 0;
      #1;
      while (bus.busy && n < 40) begin
         n++;
         if (bus.stall) sc++;
         @(negedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      bus.start = 1'b1; bus.cancel = 1'b0; bus.mulCtrl = mtMultiply;
      bus.operandA = 32'd3; bus.operandB = 32'd4; bus.mulOutputSel = 1'b0; bus.hiloUse = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", bus.busy); else passed++;
      total++; if (bus.stall !== 1'b0) $display("FAIL reset_stall got %0b want 0", bus.stall); else passed++;
      total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0)
         $display("FAIL reset_hilo got %h_%h want 0_0", bus.hi, bus.lo); else passed++;
      bus.mulCtrl = mtSetHI; bus.operandA = 32'hA5A5_0001; bus.hiloUse = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      #1;
      bus.start = 1'b0; bus.mulCtrl = mtDisabled;
      model_apply(mtSetHI, 32'hA5A5_0001, 32'd0);
      #1;
      total++; if (bus.hi !== 32'hA5A5_0001) $display("FAIL reset_first_edge_hi got %h want %h", bus.hi, 32'hA5A5_0001); else passed++;
      total++; if (bus.busy !== 1'b0) $display("FAIL reset_first_edge_busy got %0b want 0", bus.busy); else passed++;
   endtask

   task automatic test_mult;
      int n, sc; logic st0;
      run_op(mtMultiply, 32'hFFFF_FFFF, 32'd2, 1'b0, n, st0, sc);
      total++; if (n != 5) $display("FAIL mult_busy_cycles got %0d want 5", n); else passed++;
      total++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFE)
         $display("FAIL mult_hilo got %h_%h want ffffffff_fffffffe", bus.hi, bus.lo); else passed++;
      run_op(mtMultiplyUnsigned, 32'hFFFF_FFFF, 32'd2, 1'b0, n, st0, sc);
      total++; if (n != 5) $display("FAIL multu_busy_cycles got %0d want 5", n); else passed++;
      total++; if (bus.hi !== 32'd1 || bus.lo !== 32'hFFFF_FFFE)
         $display("FAIL multu_hilo got %h_%h want 00000001_fffffffe", bus.hi, bus.lo); else passed++;
      bus.mulOutputSel = 1'b1; #1;
      total++; if (bus.result !== 32'd1) $display("FAIL multu_result_hi got %h want 00000001", bus.result); else passed++;
      bus.mulOutputSel = 1'b0; #1;
      total++; if (bus.result !== 32'hFFFF_FFFE) $display("FAIL multu_result_lo got %h want fffffffe", bus.result); else passed++;
   endtask

   task automatic test_div;
      int n, sc; logic st0;
      run_op(mtDivide, 32'hFFFF_FFF9, 32'd2, 1'b0, n, st0, sc);
      total++; if (n != 10) $display("FAIL div_busy_cycles got %0d want 10", n); else passed++;
      total++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD)
         $display("FAIL div_hilo got %h_%h want ffffffff_fffffffd", bus.hi, bus.lo); else passed++;
      run_op(mtDivideUnsigned, 32'd7, 32'd0, 1'b0, n, st0, sc);
      total++; if (n != 10) $display("FAIL divu_zero_busy_cycles got %0d want 10", n); else passed++;
      total++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD)
         $display("FAIL divu_zero_hilo got %h_%h want ffffffff_fffffffd", bus.hi, bus.lo); else passed++;
      run_op(mtDivide, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, n, st0, sc);
      total++; if (bus.hi !== 32'd0 || bus.lo !== 32'h8000_0000)
         $display("FAIL div_overflow_hilo got %h_%h want 00000000_80000000", bus.hi, bus.lo); else passed++;
   endtask

   task automatic test_mt;
      int n, sc; logic st0;
      run_op(mtSetHI, 32'h1234_5678, 32'd0, 1'b1, n, st0, sc);
      total++; if (st0 !== 1'b0) $display("FAIL mthi_accept_stall got %0b want 0", st0); else passed++;
      bus.mulOutputSel = 1'b1; bus.hiloUse = 1'b1; #1;
      total++; if (bus.result !== 32'h1234_5678) $display("FAIL mfhi_result got %h want 12345678", bus.result); else passed++;
      total++; if (bus.stall !== 1'b0 || bus.busy !== 1'b0 || n != 0)
         $display("FAIL mfhi_no_stall got stall=%0b busy=%0b n=%0d want 0 0 0", bus.stall, bus.busy, n); else passed++;
      bus.hiloUse = 1'b0; bus.mulOutputSel = 1'b0;
   endtask

   task automatic test_madd_msub;
      int n, sc; logic st0;
      run_op(mtSetHI, 32'd0, 32'd0, 1'b0, n, st0, sc);
      run_op(mtSetLO, 32'hFFFF_FFFF, 32'd0, 1'b0, n, st0, sc);
      run_op(mtMADD, 32'd1, 32'd1, 1'b0, n, st0, sc);
      total++; if (bus.hi !== 32'd1 || bus.lo !== 32'd0 || n != 5)
         $display("FAIL madd_hilo got %h_%h n=%0d want 00000001_00000000 n=5", bus.hi, bus.lo, n); else passed++;
      run_op(mtSetHI, 32'd0, 32'd0, 1'b0, n, st0, sc);
      run_op(mtSetLO, 32'd0, 32'd0, 1'b0, n, st0, sc);
      run_op(mtMSUB, 32'd1, 32'd1, 1'b0, n, st0, sc);
      total++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFF)
         $display("FAIL msub_hilo got %h_%h want ffffffff_ffffffff", bus.hi, bus.lo); else passed++;
   endtask

   task automatic test_stall_cancel;
      int n, sc; logic st0;
      logic [31:0] h0, l0;
      run_op(mtDivide, 32'd100, 32'd7, 1'b1, n, st0, sc);
      total++; if (st0 !== 1'b1) $display("FAIL stall_accept got %0b want 1", st0); else passed++;
      total++; if (sc != 10 || n != 10) $display("FAIL stall_busy_cycles got %0d/%0d want 10/10", sc, n); else passed++;
      total++; if (bus.stall !== 1'b0) $display("FAIL stall_after got %0b want 0", bus.stall); else passed++;
      total++; if (bus.hi !== 32'd2 || bus.lo !== 32'd14)
         $display("FAIL stall_div_hilo got %h_%h want 00000002_0000000e", bus.hi, bus.lo); else passed++;
      h0 = bus.hi; l0 = bus.lo;
      bus.start = 1'b1; bus.cancel = 1'b1; bus.mulCtrl = mtMultiply;
      bus.operandA = 32'd9; bus.operandB = 32'd9; #1;
      total++; if (bus.stall !== 1'b0) $display("FAIL cancel_stall got %0b want 0", bus.stall); else passed++;
      @(negedge clk); #1;
      bus.start = 1'b0; bus.cancel = 1'b0; bus.mulCtrl = mtDisabled; bus.hiloUse = 1'b0; #1;
      total++; if (bus.busy !== 1'b0 || bus.hi !== h0 || bus.lo !== l0)
         $display("FAIL cancel_effect got busy=%0b %h_%h want 0 %h_%h", bus.busy, bus.hi, bus.lo, h0, l0); else passed++;
   endtask

   task automatic test_reset_mid;
      bus.start = 1'b1; bus.mulCtrl = mtMultiply; bus.operandA = 32'd1000; bus.operandB = 32'd1000;
      @(negedge clk); #1;
      bus.start = 1'b0; bus.mulCtrl = mtDisabled;
      repeat (2) @(negedge clk);
      #1;
      total++; if (bus.busy !== 1'b1) $display("FAIL reset_mid_pre_busy got %0b want 1", bus.busy); else passed++;
      reset = 1'b0; #1;
      m_hi = '0; m_lo = '0;
      total++; if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0)
         $display("FAIL reset_mid_async got busy=%0b %h_%h want 0 0_0", bus.busy, bus.hi, bus.lo); else passed++;
      @(negedge clk); #1;
      reset = 1'b1;
      repeat (8) @(negedge clk);
      #1;
      total++; if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0)
         $display("FAIL reset_mid_no_commit got busy=%0b %h_%h want 0 0_0", bus.busy, bus.hi, bus.lo); else passed++;
   endtask

   task automatic test_random_back_to_back;
      int n, sc; logic st0;
      logic [3:0]  op;
      logic [31:0] a, b;
      logic [3:0]  ops [9];
      ops = '{mtMultiply, mtMultiplyUnsigned, mtDivide, mtDivideUnsigned,
              mtSetHI, mtSetLO, mtMADD, mtMADDU, mtMSUB};
      for (int i = 0; i < 30; i++) begin
         op = ops[$urandom_range(0, 8)];
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 9));
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: ;
         endcase
         bus.mulOutputSel = 1'($urandom_range(0, 1));
         run_op(op, a, b, 1'b0, n, st0, sc);
         total++; if (n != exp_lat(op)) $display("FAIL rnd%0d_latency op=%0d got %0d want %0d", i, op, n, exp_lat(op)); else passed++;
         total++; if (bus.hi !== m_hi || bus.lo !== m_lo)
            $display("FAIL rnd%0d_hilo op=%0d a=%h b=%h got %h_%h want %h_%h", i, op, a, b, bus.hi, bus.lo, m_hi, m_lo); else passed++;
         total++; if (bus.result !== (bus.mulOutputSel ? m_hi : m_lo))
            $display("FAIL rnd%0d_result got %h want %h", i, bus.result, bus.mulOutputSel ? m_hi : m_lo); else passed++;
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.cancel = 1'b0; bus.mulCtrl = mtDisabled;
      bus.operandA = '0; bus.operandB = '0; bus.mulOutputSel = 1'b0; bus.hiloUse = 1'b0;
      test_reset();
      test_mult();
      test_div();
      test_mt();
      test_madd_msub();
      test_stall_cancel();
      test_reset_mid();
      test_random_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
